// File: rtl/approx_mult_arbiter_if.sv
// Requester-side and core-side signal bundle for approx_mult_arbiter.
// The arbiter binds to the slave modport; the requesters and core model bind to master.
interface approx_mult_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int n_input = 16
);
  // Handshake: a requester holds req[i] high with stable operands until it sees
  // a one-cycle ack[i]; the core sees a one-cycle core_start and answers with a
  // one-cycle core_done carrying core_product in the same cycle.
  logic [N_REQ-1:0]         req;
  logic [N_REQ*n_input-1:0] a_flat;
  logic [N_REQ*n_input-1:0] b_flat;
  logic [N_REQ-1:0]         ack;
  logic [2*n_input-1:0]     product;
  logic                     err;
  logic                     busy;
  logic                     core_start;
  logic [n_input-1:0]       core_a;
  logic [n_input-1:0]       core_b;
  logic                     core_done;
  logic [2*n_input-1:0]     core_product;

  modport slave (
    input  req, a_flat, b_flat, core_done, core_product,
    output ack, product, err, busy, core_start, core_a, core_b
  );

  modport master (
    output req, a_flat, b_flat, core_done, core_product,
    input  ack, product, err, busy, core_start, core_a, core_b
  );
endinterface

// File: rtl/approx_mult_arbiter.sv
// Round-robin scheduler sharing one approximate multiplier core among N_REQ requesters.
// Optional WAIT watchdog with DRAIN recovery is enabled by defining APPROX_ARB_TIMEOUT_EN.
module approx_mult_arbiter #(
  parameter int N_REQ          = 4,
  parameter int n_input        = 16,
  parameter int n_effective    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  approx_mult_arbiter_if.slave      bus,
  output logic [2:0]                dbg_state,
  output logic [$clog2(N_REQ)-1:0]  dbg_ptr
);
  localparam int IW = $clog2(N_REQ);

`ifdef APPROX_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESPOND = 3'd3, S_DRAIN = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESPOND = 3'd3
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, grant_q;
  logic [IW-1:0]        scan_idx, pick_idx;
  logic                 pick_valid;
  logic [n_input-1:0]   core_a_q, core_b_q;
  logic [2*n_input-1:0] product_q;
  logic [n_input-1:0]   a_arr [N_REQ];
  logic [n_input-1:0]   b_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.a_flat[g*n_input +: n_input];
    assign b_arr[g] = bus.b_flat[g*n_input +: n_input];
  end

  // Scan from the highest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    scan_idx   = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = IW'((int'(ptr_q) + i) % N_REQ);
      if (bus.req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

`ifdef APPROX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;
  logic          to_hit;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) to_cnt_q <= '0;
    else                          to_cnt_q <= to_cnt_q + 1'b1;
  end

  // A core_done in the expiry cycle takes priority over the timeout everywhere below.
  assign to_hit = (state_q == S_WAIT) && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (bus.core_done) err_q <= 1'b0;
      else if (to_hit)   err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pick_valid) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
`ifdef APPROX_ARB_TIMEOUT_EN
      S_WAIT:    if (bus.core_done || to_hit) state_d = S_RESPOND;
      S_RESPOND: state_d = err_q ? S_DRAIN : S_IDLE;
      S_DRAIN:   if (bus.core_done) state_d = S_IDLE;
`else
      S_WAIT:    if (bus.core_done) state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ack        = '0;
    bus.core_start = 1'b0;
    bus.busy       = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE:   bus.core_start = 1'b1;
      S_RESPOND: bus.ack[grant_q] = 1'b1;
      default:   ;
    endcase
  end

  // Operands are captured once at grant so in-flight work ignores later a_flat/b_flat changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      grant_q   <= '0;
      core_a_q  <= '0;
      core_b_q  <= '0;
      product_q <= '0;
    end else begin
      if (state_q == S_IDLE && pick_valid) begin
        grant_q  <= pick_idx;
        core_a_q <= a_arr[pick_idx];
        core_b_q <= b_arr[pick_idx];
      end
      if (state_q == S_WAIT && bus.core_done) begin
        product_q <= bus.core_product;
      end
`ifdef APPROX_ARB_TIMEOUT_EN
      else if (to_hit) begin
        product_q <= '0;
      end
`endif
      if (state_q == S_RESPOND) begin
        ptr_q <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  assign bus.core_a  = core_a_q;
  assign bus.core_b  = core_b_q;
  assign bus.product = product_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;
endmodule

// File: tb/tb_approx_mult_arbiter.sv
// Directed bench for approx_mult_arbiter: behavioural core model plus per-scenario tasks.
// The watchdog scenario runs only when APPROX_ARB_TIMEOUT_EN is defined.
module tb_approx_mult_arbiter;
  localparam int NR = 4;
  localparam int NI = 16;
`ifdef APPROX_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  logic [1:0] dbg_ptr;
  int n_checks = 0;
  int n_fail   = 0;
  int done_delay = 5;
  int spur_req   = 0;
  int spur_seen  = 0;
  int model_cnt  = -1;
  logic [31:0] prod_hold = '0;

  approx_mult_arbiter_if #(.N_REQ(NR), .n_input(NI)) ifc ();

  approx_mult_arbiter #(
    .N_REQ(NR), .n_input(NI), .n_effective(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Core model: core_done pulses done_delay cycles after core_start with the exact product.
  initial begin
    ifc.core_done    = 1'b0;
    ifc.core_product = '0;
    forever begin
      @(posedge clk); #1;
      ifc.core_done = 1'b0;
      if (spur_req != spur_seen) begin
        spur_seen        = spur_req;
        ifc.core_done    = 1'b1;
        ifc.core_product = 32'hDEAD_BEEF;
      end else if (ifc.core_start) begin
        model_cnt = done_delay;
        prod_hold = 32'(ifc.core_a) * 32'(ifc.core_b);
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) begin
          ifc.core_done    = 1'b1;
          ifc.core_product = prod_hold;
          model_cnt        = -1;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    ifc.a_flat[i*NI +: NI] = a;
    ifc.b_flat[i*NI +: NI] = b;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    ifc.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] got, output int cyc);
    got = '0;
    cyc = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (ifc.ack != '0) begin
        got = ifc.ack;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tick();
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
    n_checks++; if (ifc.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ifc.ack); end
    n_checks++; if (ifc.core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start: got %b expected 0", ifc.core_start); end
    n_checks++; if (ifc.core_a !== 16'h0 || ifc.core_b !== 16'h0) begin n_fail++; $display("FAIL reset_core_ops: got %h/%h expected 0/0", ifc.core_a, ifc.core_b); end
    n_checks++; if (ifc.product !== 32'h0 || ifc.err !== 1'b0) begin n_fail++; $display("FAIL reset_product_err: got %h/%b expected 0/0", ifc.product, ifc.err); end
    n_checks++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", dbg_ptr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    logic [3:0] got;
    int cyc;
    set_ops(0, 16'h0003, 16'h0005);
    done_delay = 5;
    ifc.req = 4'b0001;
    n_checks++; if (ifc.core_start !== 1'b0) begin n_fail++; $display("FAIL single_no_comb_start: got %b expected 0", ifc.core_start); end
    tick();
    n_checks++; if (ifc.core_start !== 1'b1) begin n_fail++; $display("FAIL single_core_start: got %b expected 1", ifc.core_start); end
    n_checks++; if (ifc.core_a !== 16'h0003 || ifc.core_b !== 16'h0005) begin n_fail++; $display("FAIL single_core_ops: got %h/%h expected 0003/0005", ifc.core_a, ifc.core_b); end
    n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", ifc.busy); end
    wait_ack(20, got, cyc);
    n_checks++; if (got !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", got); end
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL single_latency: got %0d expected 6", cyc); end
    n_checks++; if (ifc.product !== 32'h0000000F) begin n_fail++; $display("FAIL single_product: got %h expected 0000000f", ifc.product); end
    n_checks++; if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", ifc.err); end
    ifc.req = '0;
    tick();
    n_checks++; if (ifc.ack !== 4'b0000 || ifc.busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got ack %b busy %b expected 0000 0", ifc.ack, ifc.busy); end
    n_checks++; if (ifc.product !== 32'h0000000F) begin n_fail++; $display("FAIL single_hold: got %h expected 0000000f", ifc.product); end
  endtask

  task automatic test_fairness;
    logic [3:0]  exp_q[$];
    logic [31:0] prod_q[$];
    logic [3:0]  got, e;
    logic [31:0] p;
    int cyc;
    apply_reset();
    for (int i = 0; i < NR; i++) set_ops(i, 16'(i + 1), 16'(i + 2));
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        ifc.req = 4'b1111;
        exp_q  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        prod_q = '{32'd2, 32'd6, 32'd12, 32'd20};
      end else begin
        ifc.req = 4'b0101;
        exp_q  = '{4'b0001, 4'b0100};
        prod_q = '{32'd2, 32'd12};
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        p = prod_q.pop_front();
        wait_ack(20, got, cyc);
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL fair_order: got %b expected %b", got, e); end
        n_checks++; if (ifc.product !== p) begin n_fail++; $display("FAIL fair_product: got %h expected %h", ifc.product, p); end
        ifc.req = ifc.req & ~got;
        if (exp_q.size() > 0) begin
          tick();
          n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got busy %b expected 0", ifc.busy); end
          tick();
          n_checks++; if (ifc.core_start !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b expected 1", ifc.core_start); end
        end
      end
    end
    ifc.req = '0;
    tick();
  endtask

  task automatic test_pointer_resume;
    logic [3:0]  exp_q[$];
    logic [31:0] prod_q[$];
    logic [3:0]  got, e;
    logic [31:0] p;
    int cyc;
    ifc.req = 4'b0010;
    wait_ack(20, got, cyc);
    n_checks++; if (got !== 4'b0010 || ifc.product !== 32'd6) begin n_fail++; $display("FAIL resume_first: got %b/%h expected 0010/6", got, ifc.product); end
    ifc.req = '0;
    tick();
    n_checks++; if (dbg_ptr !== 2'd2) begin n_fail++; $display("FAIL resume_ptr: got %0d expected 2", dbg_ptr); end
    ifc.req = 4'b0011;
    exp_q  = '{4'b0001, 4'b0010};
    prod_q = '{32'd2, 32'd6};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      p = prod_q.pop_front();
      wait_ack(20, got, cyc);
      n_checks++; if (got !== e || ifc.product !== p) begin n_fail++; $display("FAIL resume_order: got %b/%h expected %b/%h", got, ifc.product, e, p); end
      ifc.req = ifc.req & ~got;
    end
    ifc.req = '0;
    tick();
  endtask

  task automatic test_operand_latch;
    logic [3:0] got;
    int cyc;
    ifc.req = 4'b0100;
    tick();
    n_checks++; if (ifc.core_a !== 16'd3 || ifc.core_b !== 16'd4) begin n_fail++; $display("FAIL latch_ops: got %h/%h expected 3/4", ifc.core_a, ifc.core_b); end
    set_ops(2, 16'h00FF, 16'h0101);
    wait_ack(20, got, cyc);
    n_checks++; if (got !== 4'b0100 || ifc.product !== 32'd12) begin n_fail++; $display("FAIL latch_product: got %b/%h expected 0100/c", got, ifc.product); end
    set_ops(2, 16'd3, 16'd4);
    ifc.req = '0;
    tick();
  endtask

  task automatic test_spurious_done;
    spur_req++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (ifc.ack !== 4'b0000 || ifc.busy !== 1'b0 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL spurious_idle: got ack %b busy %b state %0d expected 0000 0 0", ifc.ack, ifc.busy, dbg_state); end
    end
    n_checks++; if (ifc.product !== 32'd12) begin n_fail++; $display("FAIL spurious_product: got %h expected c", ifc.product); end
  endtask

  task automatic test_reset_in_wait;
    int bad;
    done_delay = 20;
    ifc.req = 4'b0001;
    tick();
    n_checks++; if (ifc.core_start !== 1'b1) begin n_fail++; $display("FAIL rstwait_start: got %b expected 1", ifc.core_start); end
    repeat (3) tick();
    n_checks++; if (dbg_state !== 3'd2 || dbg_ptr !== 2'd3) begin n_fail++; $display("FAIL rstwait_pre: got state %0d ptr %0d expected 2 3", dbg_state, dbg_ptr); end
    rst = 1'b1;
    ifc.req = '0;
    tick();
    n_checks++; if (ifc.busy !== 1'b0 || ifc.ack !== 4'b0000 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL rstwait_idle: got busy %b ack %b state %0d expected 0 0000 0", ifc.busy, ifc.ack, dbg_state); end
    n_checks++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL rstwait_ptr: got %0d expected 0", dbg_ptr); end
    n_checks++; if (ifc.product !== 32'h0 || ifc.core_a !== 16'h0) begin n_fail++; $display("FAIL rstwait_regs: got %h/%h expected 0/0", ifc.product, ifc.core_a); end
    rst = 1'b0;
    bad = 0;
    repeat (25) begin
      tick();
      if (ifc.ack !== 4'b0000 || ifc.busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstwait_late_done: got %0d bad cycles expected 0", bad); end
    done_delay = 5;
  endtask

`ifdef APPROX_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [3:0] got;
    int cyc, drain, bad;
    done_delay = 30;
    ifc.req = 4'b1000;
    tick();
    n_checks++; if (ifc.core_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b expected 1", ifc.core_start); end
    wait_ack(20, got, cyc);
    ifc.req = '0;
    n_checks++; if (got !== 4'b1000 || cyc !== 9) begin n_fail++; $display("FAIL to_ack: got %b after %0d expected 1000 after 9", got, cyc); end
    n_checks++; if (ifc.err !== 1'b1 || ifc.product !== 32'h0) begin n_fail++; $display("FAIL to_err: got %b/%h expected 1/0", ifc.err, ifc.product); end
    drain = 0;
    bad = 0;
    while (ifc.busy === 1'b1 && drain < 40) begin
      tick();
      drain++;
      if (ifc.ack !== 4'b0000) bad++;
    end
    n_checks++; if (drain !== 22 || bad !== 0) begin n_fail++; $display("FAIL to_drain: got %0d cycles %0d acks expected 22 0", drain, bad); end
    done_delay = 5;
  endtask
`endif

  initial begin
    ifc.req    = '0;
    ifc.a_flat = '0;
    ifc.b_flat = '0;
    test_reset();
    test_single();
    test_fairness();
    test_pointer_resume();
    test_operand_latch();
    test_spurious_done();
    test_reset_in_wait();
`ifdef APPROX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/approx_mult_arbiter.md
Name: approx_mult_arbiter

Overview:
- Round-robin scheduler that shares one approximate multiplier core among N_REQ requesters.
- Latches the granted requester's operands and drives the core's start/done handshake.
- Returns the product with a one-cycle ack pulse to the granted requester.
- Sits between the requester blocks (filters and accumulators) and the single multiplier instance, so the core's area is paid only once.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- n_input, 16, operand width in bits.
- n_effective, 8, effective width passed through to the core instance; the arbiter does not use it.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  level request per requester; held high until ack.
- a_flat  input  N_REQ*n_input  operand A per requester; requester i uses bits [i*n_input +: n_input].
- b_flat  input  N_REQ*n_input  operand B per requester, same packing.
- ack  output  N_REQ  one-hot, one-cycle completion pulse.
- product  output  2*n_input  result; valid while ack != 0, holds its value otherwise.
- err  output  1  timeout flag; valid with ack.
- busy  output  1  high in any state other than IDLE.
- core_start  output  1  one-cycle start pulse to the core.
- core_a  output  n_input  latched operand A.
- core_b  output  n_input  latched operand B.
- core_done  input  1  core completion; sampled only in WAIT and DRAIN.
- core_product  input  2*n_input  core result; sampled in the cycle core_done=1.

Behaviour:
- Reset (synchronous): state=IDLE, ptr=0, grant index=0, ack=0, core_start=0, core_a=0, core_b=0, product=0, err=0, busy=0.
- Reset mid-operation (any state) returns to IDLE with the values above. No ack is issued. The core shares rst.
- FSM states: IDLE, ISSUE, WAIT, RESPOND, DRAIN (DRAIN exists only with the optional feature).
- IDLE:
  - If any req is high, grant the first requester found searching ptr, ptr+1, ... mod N_REQ.
  - Latch its operands into core_a/core_b and store the grant index; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: core_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On core_done=1, latch product <= core_product, err <= 0, go to RESPOND.
  - Otherwise stay.
- RESPOND:
  - ack[grant]=1 for this cycle only; go to IDLE.
  - ptr <= (grant+1) mod N_REQ, which gives wrap-around at N_REQ-1 -> 0.
- Requester contract:
  - Keep operands stable while req is high.
  - Deassert req in the cycle after ack. A req still high in the following IDLE cycle is a new request.
- core_done outside WAIT/DRAIN is ignored: no state change, no ack.
- Operands are latched once at grant. Later changes on a_flat/b_flat do not affect an operation in flight.
- Arbitration is evaluated only in IDLE. A req rising during ISSUE/WAIT/RESPOND waits for the next IDLE.
- Latency: req high in IDLE cycle t -> core_start at t+1. core_done at cycle d -> ack at d+1. Dead time between back-to-back grants is one IDLE cycle.
- All outputs are registered or decoded directly from the state register. No combinational path from req to core_start.

Optional Feature:
- Macro APPROX_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse without core_done, go to RESPOND with err=1 and product=0.
  - Then go to DRAIN instead of IDLE. DRAIN holds busy=1 until core_done=1, discards that core_product, then goes to IDLE. No ack is issued from DRAIN.
  - core_done arriving in the same cycle the counter expires counts as normal completion (err=0).
- When undefined: no counter, no DRAIN state, err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single request: req=4'b0001, a=16'h0003, b=16'h0005; core model with done 5 cycles after start returning 32'h0000000F -> core_start one cycle after req, ack=4'b0001 one cycle after done, product=32'h0000000F, err=0.
- Fairness: req=4'b1111 held, each requester dropping req after its own ack -> ack order 0,1,2,3. Then req=4'b0101 -> order 0,2, since ptr wrapped to 0.
- Pointer resume: after servicing requester 1, assert req=4'b0011 -> requester 0 is served after requester 1's slot passes (order 0 only after ptr=2 search wraps), confirming no starvation.
- Reset in WAIT: rst=1 for one cycle before core_done -> ack never pulses, busy=0, ptr=0 the next cycle. A later core_done in IDLE is ignored.
- Spurious done: core_done=1 while in IDLE with req=0 -> state remains IDLE, ack=0, product unchanged.
- With APPROX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, core never signals done -> ack with err=1 and product=0 nine cycles after core_start. busy stays 1 until the delayed core_done arrives, then falls.
